// File: rtl/csa_serial_sub_if.sv
// ----------------------------------------------------------------------------
// csa_serial_sub_if
//   Bundles the request/response signals of the serial carry-select
//   subtractor so the controlling datapath and the subtractor share a single
//   connection.
//
//   Signals
//     start  request, sampled by the subtractor only when it is idle/done
//     A      minuend     (WIDTH bits)
//     B      subtrahend  (WIDTH bits)
//     Bin    borrow in
//     busy   subtractor is running
//     done   one-cycle pulse, D/Bout valid
//     D      difference modulo 2^WIDTH
//     Bout   borrow out (A < B + Bin, unsigned)
//     V      two's-complement overflow (only with CSA_SUB_OVF_EN defined)
//
//   Modports
//     master  controlling datapath (drives the request side)
//     slave   subtractor           (drives the response side)
// ----------------------------------------------------------------------------
interface csa_serial_sub_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] D;
   logic             Bout;
`ifdef CSA_SUB_OVF_EN
   logic             V;

   modport master (
      output start, A, B, Bin,
      input  busy, done, D, Bout, V
   );

   modport slave (
      input  start, A, B, Bin,
      output busy, done, D, Bout, V
   );
`else
   modport master (
      output start, A, B, Bin,
      input  busy, done, D, Bout
   );

   modport slave (
      input  start, A, B, Bin,
      output busy, done, D, Bout
   );
`endif
endinterface

// File: rtl/csa_serial_sub.sv
// ----------------------------------------------------------------------------
// csa_serial_sub
//   Multi-cycle subtractor D = A - B - Bin. The operands are consumed DIGIT
//   bits per clock, least significant slice first. Each slice is computed in
//   carry-select form: both the borrow-in=0 and borrow-in=1 differences are
//   formed and the registered borrow from the previous slice picks one. A
//   WIDTH=16 / DIGIT=4 instance produces one result every 5 cycles.
//
//   Parameters
//     WIDTH  operand/result width, must be a multiple of DIGIT
//     DIGIT  bits processed per clock (N = WIDTH/DIGIT slices, N=1 is legal)
//
//   Ports
//     clk    rising-edge clock
//     rst    asynchronous, active-high reset; aborts any operation in flight
//     bus    csa_serial_sub_if.slave:
//              start/A/B/Bin in, busy/done/D/Bout out (+ V, see below)
//
//   Timing
//     start sampled in IDLE or DONE -> RUN for N cycles -> DONE for one
//     cycle (done=1). Holding start in DONE relatches and restarts without an
//     IDLE cycle. start during RUN is ignored. D/Bout hold the last result
//     until the next accepted start; partial slices show up in D during RUN.
//
//   Build option
//     CSA_SUB_OVF_EN  when defined, adds output V (two's-complement
//                     overflow), registered with the final slice and valid
//                     with done. When undefined there is no V logic.
// ----------------------------------------------------------------------------
module csa_serial_sub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   csa_serial_sub_if.slave bus
);

   localparam int N     = WIDTH / DIGIT;
   // A 1-bit counter is kept even for N=1 so the slice index is never empty.
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic [WIDTH-1:0] d_q,     d_d;
   logic             brw_q,   brw_d;
   logic             bout_q,  bout_d;
`ifdef CSA_SUB_OVF_EN
   logic             v_q,     v_d;
`endif

   logic [DIGIT-1:0] a_s;
   logic [DIGIT-1:0] b_s;
   logic [DIGIT:0]   dif0;
   logic [DIGIT:0]   dif1;
   logic [DIGIT:0]   dif_sel;
   logic             accept;

   // One slice difference a - b - bin, one bit wider than the slice; the MSB
   // is the borrow out of the slice (the true result lies in [-2^DIGIT, 2^DIGIT)).
   function automatic logic [DIGIT:0] slice_sub(
      input logic [DIGIT-1:0] a,
      input logic [DIGIT-1:0] b,
      input logic             bin
   );
      slice_sub = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
   endfunction

   // ---- slice datapath: carry-select between borrow-in 0 and 1 ----
   always_comb begin
      a_s     = a_q[int'(cnt_q)*DIGIT +: DIGIT];
      b_s     = b_q[int'(cnt_q)*DIGIT +: DIGIT];
      dif0    = slice_sub(a_s, b_s, 1'b0);
      dif1    = slice_sub(a_s, b_s, 1'b1);
      dif_sel = brw_q ? dif1 : dif0;
   end

   // A request is honoured only when no operation is in flight.
   assign accept = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

   // ---- next-state / control ----
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      d_d     = d_q;
      brw_d   = brw_q;
      bout_d  = bout_q;
`ifdef CSA_SUB_OVF_EN
      v_d     = v_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               a_d     = bus.A;
               b_d     = bus.B;
               brw_d   = bus.Bin;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            d_d[int'(cnt_q)*DIGIT +: DIGIT] = dif_sel[DIGIT-1:0];
            brw_d = dif_sel[DIGIT];
            if (cnt_q == CNT_LAST) begin
               // Final (most significant) slice: the borrow is the result
               // borrow and the slice MSB is the result sign bit.
               cnt_d   = '0;
               bout_d  = dif_sel[DIGIT];
`ifdef CSA_SUB_OVF_EN
               v_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                         (dif_sel[DIGIT-1] != a_q[WIDTH-1]);
`endif
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---- registers ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         brw_q   <= 1'b0;
         bout_q  <= 1'b0;
`ifdef CSA_SUB_OVF_EN
         v_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         d_q     <= d_d;
         brw_q   <= brw_d;
         bout_q  <= bout_d;
`ifdef CSA_SUB_OVF_EN
         v_q     <= v_d;
`endif
      end
   end

   // ---- outputs ----
   assign bus.busy = (state_q == S_RUN);
   assign bus.done = (state_q == S_DONE);
   assign bus.D    = d_q;
   assign bus.Bout = bout_q;
`ifdef CSA_SUB_OVF_EN
   assign bus.V    = v_q;
`endif

endmodule

// File: tb/tb_csa_serial_sub.sv
module tb_csa_serial_sub;

   localparam int N16 = 4;

   logic clk;
   logic rst;

   int nvec;
   int nfail;

   csa_serial_sub_if #(.WIDTH(16)) bus16 ();
   csa_serial_sub_if #(.WIDTH(4))  bus4  ();

   csa_serial_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   csa_serial_sub #(.WIDTH(4), .DIGIT(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model for the 16-bit instance: an accepted request
   // finishes N cycles later with A-B-Bin computed as plain 17-bit
   // arithmetic; the result then holds until the next one finishes.
   // ------------------------------------------------------------------
   int          e;
   int          acc_e;
   bit          has_op;
   logic [15:0] pend_d, res_d;
   logic        pend_b, res_b;
   logic        pend_v, res_v;

   initial begin : model_and_compare
      logic [16:0] diff;
      bit running;
      bit exp_done;
      e = 0; acc_e = 0; has_op = 0;
      res_d = '0; res_b = 1'b0; res_v = 1'b0;
      pend_d = '0; pend_b = 1'b0; pend_v = 1'b0;
      forever begin
         @(posedge clk);
         if (!rst) begin
            e++;
            if (has_op && e == acc_e + N16) begin
               res_d = pend_d; res_b = pend_b; res_v = pend_v;
            end
            if (bus16.start && (!has_op || e >= acc_e + N16 + 1)) begin
               diff   = {1'b0, bus16.A} - {1'b0, bus16.B} - {16'd0, bus16.Bin};
               pend_d = diff[15:0];
               pend_b = diff[16];
               pend_v = (bus16.A[15] != bus16.B[15]) && (diff[15] != bus16.A[15]);
               acc_e  = e;
               has_op = 1;
            end
         end
         @(negedge clk);
         if (rst) begin
            has_op = 0;
            res_d = '0; res_b = 1'b0; res_v = 1'b0;
            chk("rst_busy", 32'(bus16.busy), 32'd0);
            chk("rst_done", 32'(bus16.done), 32'd0);
            chk("rst_D",    32'(bus16.D),    32'd0);
            chk("rst_Bout", 32'(bus16.Bout), 32'd0);
         end else begin
            running  = has_op && (e >= acc_e) && (e < acc_e + N16);
            exp_done = has_op && (e == acc_e + N16);
            chk("busy", 32'(bus16.busy), 32'(running));
            chk("done", 32'(bus16.done), 32'(exp_done));
            if (!running) begin
               chk("D",    32'(bus16.D),    32'(res_d));
               chk("Bout", 32'(bus16.Bout), 32'(res_b));
`ifdef CSA_SUB_OVF_EN
               chk("V",    32'(bus16.V),    32'(res_v));
`endif
            end
         end
      end
   end

   // Single request, wait (bounded) for done, compare against literals.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         input logic [15:0] exp_d, input logic exp_bout);
      int lat;
      @(posedge clk); #2;
      bus16.A = a; bus16.B = b; bus16.Bin = bin; bus16.start = 1'b1;
      @(posedge clk); #2;
      bus16.start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (bus16.done) begin
            lat = k;
            break;
         end
      end
      chk("op_latency", 32'(lat), 32'd5);
      chk("op_D",       32'(bus16.D),    32'(exp_d));
      chk("op_Bout",    32'(bus16.Bout), 32'(exp_bout));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, nfail=%0d", nfail);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat, busy_cnt, dones;
      logic [4:0] exp5;
      nvec = 0; nfail = 0;
      rst = 1'b1;
      bus16.start = 1'b0; bus16.A = '0; bus16.B = '0; bus16.Bin = 1'b0;
      bus4.start  = 1'b0; bus4.A  = '0; bus4.B  = '0; bus4.Bin  = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // basic vectors and boundaries
      run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
      run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
      run_op(16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0);
      run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
      run_op(16'h0F0F, 16'h00FF, 1'b1, 16'h0E0F, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
`ifdef CSA_SUB_OVF_EN
      chk("ovf_V_8000", 32'(bus16.V), 32'd1);
`endif
      run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);
`ifdef CSA_SUB_OVF_EN
      chk("ovf_V_0005", 32'(bus16.V), 32'd0);
`endif

      // start held through RUN with changing operands: single result
      @(posedge clk); #2;
      bus16.A = 16'h00F0; bus16.B = 16'h000F; bus16.Bin = 1'b0; bus16.start = 1'b1;
      @(posedge clk); #2;
      bus16.A = 16'h1111; bus16.B = 16'h2222; bus16.Bin = 1'b1;
      lat = 0; busy_cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (bus16.busy) busy_cnt++;
         if (bus16.done) begin
            lat = k;
            bus16.start = 1'b0;
            break;
         end
      end
      bus16.start = 1'b0;
      chk("hold_latency", 32'(lat), 32'd5);
      chk("hold_busy_cycles", 32'(busy_cnt), 32'd4);
      chk("hold_D", 32'(bus16.D), 32'h00E1);
      dones = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus16.done) dones++;
      end
      chk("hold_extra_done", 32'(dones), 32'd0);

      // reset two cycles into RUN aborts the operation
      @(posedge clk); #2;
      bus16.A = 16'h1234; bus16.B = 16'h0234; bus16.Bin = 1'b0; bus16.start = 1'b1;
      @(posedge clk); #2;
      bus16.start = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(bus16.busy), 32'd0);
      chk("abort_D",    32'(bus16.D),    32'd0);
      chk("abort_Bout", 32'(bus16.Bout), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      dones = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus16.done) dones++;
      end
      chk("abort_no_done", 32'(dones), 32'd0);
      run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);

      // back-to-back: start held in DONE relatches with no IDLE cycle
      @(posedge clk); #2;
      bus16.A = 16'h1234; bus16.B = 16'h0234; bus16.Bin = 1'b0; bus16.start = 1'b1;
      @(posedge clk); #2;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (bus16.done) begin
            lat = k;
            break;
         end
      end
      chk("b2b_first_latency", 32'(lat), 32'd5);
      chk("b2b_first_D", 32'(bus16.D), 32'h1000);
      bus16.A = 16'hABCD; bus16.B = 16'h1234; bus16.Bin = 1'b1;
      @(posedge clk); #2;
      bus16.start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) chk("b2b_no_idle", 32'(bus16.busy), 32'd1);
         if (bus16.done) begin
            lat = k;
            break;
         end
      end
      chk("b2b_second_gap", 32'(lat), 32'd5);
      chk("b2b_second_D",    32'(bus16.D),    32'h9998);
      chk("b2b_second_Bout", 32'(bus16.Bout), 32'd0);

      // N=1 instance: exhaustive sweep of all A, B, Bin
      @(posedge clk); #2;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int bin = 0; bin < 2; bin++) begin
               bus4.A = 4'(a); bus4.B = 4'(b); bus4.Bin = bin[0]; bus4.start = 1'b1;
               @(posedge clk); #2;
               bus4.start = 1'b0;
               @(negedge clk);
               chk("n1_busy", 32'(bus4.busy), 32'd1);
               @(negedge clk);
               exp5 = 5'(a - b - bin);
               chk("n1_done", 32'(bus4.done), 32'd1);
               chk("n1_result", 32'({bus4.Bout, bus4.D}), 32'(exp5));
               @(posedge clk); #2;
            end
         end
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
